fetch_controller: RTL
=====================

// Module: fetch_controller
// PURPOSE
//   Drives the instruction fetch stage. Sequences the PC and issues word
//   addresses to the synchronous instruction_memory (1-cycle read latency).
//   Presents fetched instructions to decode over a valid/ready handshake,
//   using a one-entry skid buffer so back-pressure never loses a response.
//   Sits between branch/jump resolution (redirect) and the decode stage.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC fetched first after reset (bits [1:0] forced to 0)
//   PC_STEP   4              byte increment between sequential fetches
// PORTS
//   clk            in   1        clock; all state updates on posedge
//   rst            in   1        asynchronous, active-high reset
//   i_redirect     in   1        load new PC; squashes in-flight and buffered fetches
//   i_redirect_pc  in   ADDR_W   redirect target (bits [1:0] ignored, treated as 0)
//   o_mem_addr     out  ADDR_W   address to instruction_memory i_req_addr
//   i_mem_data     in   INSTR_W  instruction_memory o_res_data (valid 1 cycle after addr)
//   o_valid        out  1        o_instr/o_pc hold a live instruction
//   i_ready        in   1        decode accepts this cycle (transfer = o_valid & i_ready)
//   o_instr        out  INSTR_W  instruction to decode
//   o_pc           out  ADDR_W   byte address of o_instr
// BEHAVIOUR
// - State regs: pc (next fetch addr), inflight_v/inflight_pc, skid_v/skid_instr/skid_pc.
// - FSM is the encoding of (inflight_v, skid_v); (1,1) is unreachable:
//     EMPTY (0,0)  nothing outstanding
//     STREAM (1,0) response arrives on i_mem_data this cycle
//     HELD (0,1)   response parked in skid buffer
// - issue = (!skid_v | i_ready) & !(inflight_v & !i_ready). When issue=1: inflight_v<=1,
//   inflight_pc<=o_mem_addr, pc<=o_mem_addr+PC_STEP. Otherwise inflight_v<=0 and pc holds.
// - o_mem_addr = i_redirect ? {i_redirect_pc[ADDR_W-1:2],2'b00} : pc (combinational).
// - o_valid = (skid_v | inflight_v) & !i_redirect. The instr/pc mux selects skid when
//   skid_v, else i_mem_data/inflight_pc.
// - Transitions when i_redirect=0:
//     EMPTY           -> STREAM (issue)
//     STREAM, ready   -> STREAM (zero-bubble; 1 instr/cycle)
//     STREAM, !ready  -> HELD (skid <= i_mem_data, inflight_pc; no issue)
//     HELD, ready     -> STREAM (skid drains, issue same cycle)
//     HELD, !ready    -> HELD (all outputs stable)
// - i_redirect=1, from any state: skid_v<=0; target issued this cycle; next state
//   STREAM; target appears with o_valid=1 on the next cycle. Redirect beats i_ready:
//   an instruction presented in the redirect cycle is not transferred.
// - Redirect latency: 1 cycle, target to o_valid. Steady-state throughput: 1/cycle.
// - pc arithmetic is modulo 2^ADDR_W; pc 'hFFFF_FFFC + 4 wraps to 0. No fault is raised.
// - Addresses past memory depth are issued normally. The memory returns NOP; no special case.
// - rst asserted at any time, async: pc<=RESET_PC, inflight_v<=0, skid_v<=0. o_valid=0
//   while rst=1. First issue (addr RESET_PC) in the first cycle after rst deasserts.
// - Reset values: o_valid=0, o_mem_addr=RESET_PC, o_pc=RESET_PC (inflight_pc reset
//   value), o_instr=i_mem_data passthrough (don't-care while o_valid=0).
// - While o_valid=1 & !i_ready, o_instr/o_pc must not change (except on redirect or rst).
// STRUCTURE
// - ADDR_W and INSTR_W come from config.vh. NOP encoding and opcode fields come from
//   opcodes.vh. State encodings FETCH_EMPTY/STREAM/HELD go into a shared fetch_codes.vh.
// - One natural sub-module: fetch_skid_buffer (1-entry valid/ready register slice
//   carrying {pc, instr}). pc/inflight logic stays in fetch_controller.
// TESTING
// - Reset release, i_ready=1: o_mem_addr 0,4,8... each cycle. o_valid=1 from cycle 2.
//   o_pc 0,4,8,..., o_instr equals the preloaded memory words, no bubbles.
// - Hold i_ready=0 for 3 cycles while STREAM at pc 8: o_pc=8 and o_instr stay stable.
//   No new addr is issued. On release, o_pc 8 then 12 on consecutive cycles.
// - Redirect to 'h40 while HELD with skid pc 8: same cycle o_valid=0. Next cycle o_pc='h40.
//   pc 8/12 are never transferred.
// - Redirect with i_redirect_pc='h43 and i_ready=1: o_mem_addr='h40, then o_pc='h40.
//   The instruction shown in the redirect cycle is not counted as accepted.
// - Assert rst mid-stream, asynchronously between edges: o_valid drops immediately.
//   After release, fetch restarts at RESET_PC.
// - RESET_PC='hFFFF_FFF8, ready=1: o_pc 'hFFFF_FFF8, 'hFFFF_FFFC, 0. Memory out of range returns NOP.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ADDR_W / INSTR_W : address and instruction widths
//   PC_STEP_DEF      : default byte increment between sequential fetches
//   NOP_INSTR        : encoding returned by memory for unmapped addresses
//   fetch_state_e    : fetch FSM states, encoded as {inflight_v, skid_v}
//   word_align()     : clears the byte-offset bits of an address
package fetch_controller_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP_DEF = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR   = 32'h0000_0013;

  // Bit 1 = a memory response is due this cycle, bit 0 = skid holds a response.
  // {1,1} cannot occur: a response is only parked when no new fetch is issued.
  typedef enum logic [1:0] {
    FETCH_EMPTY  = 2'b00,
    FETCH_STREAM = 2'b10,
    FETCH_HELD   = 2'b01
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_skid_buffer.sv
// One-entry skid register carrying {pc, instr} between memory and decode.
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : capture pc_i/instr_i (decode stalled while a response lands)
//   sel_i     : present the parked entry instead of the live response
//   pc_i      : pc of the response arriving this cycle
//   instr_i   : instruction arriving from memory this cycle
//   pc_o      : pc presented to decode
//   instr_o   : instruction presented to decode
module fetch_controller_skid_buffer
  import fetch_controller_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               sel_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic [ADDR_W-1:0]  skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;

  // Parked payload register; only written when a response cannot be handed over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_pc_q    <= RESET_PC;
      skid_instr_q <= {INSTR_W{1'b0}};
    end else if (load_i) begin
      skid_pc_q    <= pc_i;
      skid_instr_q <= instr_i;
    end else begin
      skid_pc_q    <= skid_pc_q;
      skid_instr_q <= skid_instr_q;
    end
  end

  assign pc_o    = sel_i ? skid_pc_q    : pc_i;
  assign instr_o = sel_i ? skid_instr_q : instr_i;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer. Issues word addresses to a synchronous
// instruction memory (1-cycle read latency) and hands the responses to
// decode over valid/ready, with a skid entry so a stall never drops a
// response. A redirect squashes everything outstanding and fetches the target.
//   clk, rst       : clock, asynchronous active-high reset
//   i_redirect     : load new pc, squash in-flight and parked fetches
//   i_redirect_pc  : redirect target (byte offset ignored)
//   o_mem_addr     : read address to instruction memory
//   i_mem_data     : memory read data for last cycle's address
//   o_valid        : o_instr/o_pc carry a live instruction
//   i_ready        : decode accepts this cycle
//   o_instr, o_pc  : instruction to decode and its byte address
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [INSTR_W-1:0] i_mem_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);

  localparam logic [ADDR_W-1:0] RESET_PC_AL = word_align(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_v, skid_v, issue, skid_load;

  assign inflight_v = (state_q == FETCH_STREAM);
  assign skid_v     = (state_q == FETCH_HELD);

  // A fetch goes out unless a stalled response would be overrun; redirect always fetches.
  assign issue      = i_redirect | ((!skid_v | i_ready) & !(inflight_v & !i_ready));

  assign o_mem_addr = i_redirect ? word_align(i_redirect_pc) : pc_q;
  assign o_valid    = (inflight_v | skid_v) & !i_redirect;

  // Next-state decode; a stalled live response is parked in the skid entry.
  always_comb begin
    state_d   = state_q;
    skid_load = 1'b0;
    if (i_redirect) begin
      state_d = FETCH_STREAM;
    end else begin
      case (state_q)
        FETCH_EMPTY:  state_d = FETCH_STREAM;
        FETCH_STREAM: begin
          if (i_ready) begin
            state_d = FETCH_STREAM;
          end else begin
            state_d   = FETCH_HELD;
            skid_load = 1'b1;
          end
        end
        FETCH_HELD:   state_d = i_ready ? FETCH_STREAM : FETCH_HELD;
        default:      state_d = FETCH_EMPTY;
      endcase
    end
  end

  // PC and in-flight address advance only when a fetch is issued (wraps modulo 2^ADDR_W).
  always_comb begin
    if (issue) begin
      pc_d          = o_mem_addr + PC_STEP;
      inflight_pc_d = o_mem_addr;
    end else begin
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
    end
  end

  // State, pc and in-flight address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH_EMPTY;
      pc_q          <= RESET_PC_AL;
      inflight_pc_q <= RESET_PC_AL;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_controller_skid_buffer #(
    .RESET_PC (RESET_PC_AL)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .sel_i   (skid_v),
    .pc_i    (inflight_pc_q),
    .instr_i (i_mem_data),
    .pc_o    (o_pc),
    .instr_o (o_instr)
  );

endmodule
